// File: rtl/scpad_frontend_arb.sv
// Scratchpad SRAM request arbiter: fixed FE priority with a BE starvation bound, one-entry output
// stage, and a source-tag pipe that routes read data. Optional counters: SCPAD_ARB_PERF_EN.
module scpad_frontend_arb #(
    parameter int unsigned NUM_COLS      = 32,
    parameter int unsigned ELEM_BITS     = 16,
    parameter int unsigned ROW_IDX_WIDTH = 14,
    parameter int unsigned COL_IDX_WIDTH = 5,
    parameter int unsigned SRAM_LAT      = 3,
    parameter int unsigned STARVE_LIMIT  = 8
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic                                fe_req_valid,
    output logic                                fe_req_ready,
    input  logic                                fe_req_write,
    input  logic                                fe_req_scpad_id,
    input  logic [NUM_COLS*ROW_IDX_WIDTH-1:0]   fe_req_slot,
    input  logic [NUM_COLS*COL_IDX_WIDTH-1:0]   fe_req_shift,
    input  logic [NUM_COLS-1:0]                 fe_req_mask,
    input  logic [NUM_COLS*ELEM_BITS-1:0]       fe_req_wdata,

    input  logic                                be_req_valid,
    output logic                                be_req_ready,
    input  logic                                be_req_write,
    input  logic                                be_req_scpad_id,
    input  logic [NUM_COLS*ROW_IDX_WIDTH-1:0]   be_req_slot,
    input  logic [NUM_COLS*COL_IDX_WIDTH-1:0]   be_req_shift,
    input  logic [NUM_COLS-1:0]                 be_req_mask,
    input  logic [NUM_COLS*ELEM_BITS-1:0]       be_req_wdata,

    output logic                                sram_req_valid,
    input  logic                                sram_req_ready,
    output logic                                sram_req_write,
    output logic                                sram_req_scpad_id,
    output logic [NUM_COLS*ROW_IDX_WIDTH-1:0]   sram_req_slot,
    output logic [NUM_COLS*COL_IDX_WIDTH-1:0]   sram_req_shift,
    output logic [NUM_COLS-1:0]                 sram_req_mask,
    output logic [NUM_COLS*ELEM_BITS-1:0]       sram_req_wdata,
    output logic                                sram_req_src,

    input  logic                                sram_rsp_valid,
    input  logic [NUM_COLS*ELEM_BITS-1:0]       sram_rsp_rdata,

    output logic                                fe_rsp_valid,
    output logic [NUM_COLS*ELEM_BITS-1:0]       fe_rsp_rdata,
    output logic                                be_rsp_valid,
    output logic [NUM_COLS*ELEM_BITS-1:0]       be_rsp_rdata,

    output logic                                rsp_err,
    output logic [31:0]                         perf_fe_grants,
    output logic [31:0]                         perf_be_grants,
    output logic [31:0]                         perf_conflicts
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {SRC_FE = 1'b0, SRC_BE = 1'b1} src_t;

    typedef struct packed {
        logic                              write;
        logic                              scpad_id;
        logic [NUM_COLS*ROW_IDX_WIDTH-1:0] slot;
        logic [NUM_COLS*COL_IDX_WIDTH-1:0] shift;
        logic [NUM_COLS-1:0]               mask;
        logic [NUM_COLS*ELEM_BITS-1:0]     wdata;
    } req_t;

    req_t             fe_bundle, be_bundle, ostage_q;
    src_t             ostage_src_q;
    logic             ostage_valid_q;
    logic             can_accept, grant_fe, grant_be;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [SRAM_LAT-1:0] tag_valid_q, tag_src_q;
    logic             rd_hs, tag_last_valid, rsp_err_q;

    assign fe_bundle = '{write: fe_req_write, scpad_id: fe_req_scpad_id, slot: fe_req_slot,
                         shift: fe_req_shift, mask: fe_req_mask, wdata: fe_req_wdata};
    assign be_bundle = '{write: be_req_write, scpad_id: be_req_scpad_id, slot: be_req_slot,
                         shift: be_req_shift, mask: be_req_mask, wdata: be_req_wdata};

    assign can_accept = !ostage_valid_q || sram_req_ready;

    always_comb begin
        grant_fe = 1'b0;
        grant_be = 1'b0;
        if (!rst && can_accept) begin
            if (be_req_valid && starve_q == STARVE_MAX) begin
                grant_be = 1'b1;
            end else if (fe_req_valid) begin
                grant_fe = 1'b1;
            end else if (be_req_valid) begin
                grant_be = 1'b1;
            end
        end
    end

    assign fe_req_ready = grant_fe;
    assign be_req_ready = grant_be;

    // A cycle where BE is valid but not granted while accepting is an FE win.
    always_comb begin
        starve_d = starve_q;
        if (can_accept) begin
            if (!be_req_valid || grant_be) begin
                starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q       <= '0;
            ostage_valid_q <= 1'b0;
            ostage_q       <= '0;
            ostage_src_q   <= SRC_FE;
        end else begin
            starve_q <= starve_d;
            if (can_accept) begin
                ostage_valid_q <= grant_fe || grant_be;
                if (grant_fe) begin
                    ostage_q     <= fe_bundle;
                    ostage_src_q <= SRC_FE;
                end else if (grant_be) begin
                    ostage_q     <= be_bundle;
                    ostage_src_q <= SRC_BE;
                end
            end
        end
    end

    assign sram_req_valid    = ostage_valid_q;
    assign sram_req_write    = ostage_q.write;
    assign sram_req_scpad_id = ostage_q.scpad_id;
    assign sram_req_slot     = ostage_q.slot;
    assign sram_req_shift    = ostage_q.shift;
    assign sram_req_mask     = ostage_q.mask;
    assign sram_req_wdata    = ostage_q.wdata;
    assign sram_req_src      = ostage_src_q;

    assign rd_hs = ostage_valid_q && sram_req_ready && !ostage_q.write;

    // Bit 0 is the newest stage; the concat-and-truncate also covers SRAM_LAT == 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_src_q   <= '0;
        end else begin
            tag_valid_q <= SRAM_LAT'({tag_valid_q, rd_hs});
            tag_src_q   <= SRAM_LAT'({tag_src_q, ostage_src_q == SRC_BE});
        end
    end

    assign tag_last_valid = tag_valid_q[SRAM_LAT-1];

    assign fe_rsp_valid = !rst && sram_rsp_valid && tag_last_valid && !tag_src_q[SRAM_LAT-1];
    assign be_rsp_valid = !rst && sram_rsp_valid && tag_last_valid && tag_src_q[SRAM_LAT-1];
    assign fe_rsp_rdata = sram_rsp_rdata;
    assign be_rsp_rdata = sram_rsp_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (sram_rsp_valid != tag_last_valid) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;

`ifdef SCPAD_ARB_PERF_EN
    logic [31:0] perf_fe_q, perf_be_q, perf_cf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fe_q <= '0;
            perf_be_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_fe_q <= perf_fe_q + {31'd0, grant_fe};
            perf_be_q <= perf_be_q + {31'd0, grant_be};
            perf_cf_q <= perf_cf_q + {31'd0, can_accept && fe_req_valid && be_req_valid};
        end
    end

    assign perf_fe_grants = perf_fe_q;
    assign perf_be_grants = perf_be_q;
    assign perf_conflicts = perf_cf_q;
`else
    assign perf_fe_grants = 32'd0;
    assign perf_be_grants = 32'd0;
    assign perf_conflicts = 32'd0;
`endif

endmodule
